// File: rtl/alarm_setter.sv
// Alarm time editor: edge-detected buttons drive a hour/minute BCD edit FSM with shadow/committed registers.
// Optional define ALARM_DEC_EN enables the btn_dec decrement path.
module alarm_setter #(
  parameter logic [7:0] RESET_HOUR_BCD = 8'h06,
  parameter logic [7:0] RESET_MIN_BCD  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Set_Alarm,
  input  logic       Alarm_off,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [3:0] hour_al_tens,
  output logic [3:0] hour_al_unit,
  output logic [3:0] min_al_tens,
  output logic [3:0] min_al_unit,
  output logic [3:0] seg_al_tens,
  output logic [3:0] seg_al_unit,
  output logic       setting,
  output logic       alarm_armed,
  output logic       commit_pulse
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_EDIT_HOUR = 2'd1;
  localparam logic [1:0] S_EDIT_MIN  = 2'd2;
  localparam logic [1:0] S_COMMIT    = 2'd3;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  logic [1:0] r_state;
  logic [7:0] r_com_hour, r_com_min;
  logic [7:0] r_sh_hour,  r_sh_min;
  logic       r_armed;
  logic       r_set_q, r_off_q, r_next_q, r_inc_q;

  logic       w_set_edge, w_off_edge, w_next_edge, w_inc_edge, w_dec_edge;
  logic       w_inc_only, w_dec_only;
  logic [7:0] w_field, w_field_max, w_field_nxt;
  logic       w_edit_hour;

  // BCD step with wrap at max; units digit 9 carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_set_edge  = Set_Alarm & ~r_set_q;
  assign w_off_edge  = Alarm_off & ~r_off_q;
  assign w_next_edge = btn_next  & ~r_next_q;
  assign w_inc_edge  = btn_inc   & ~r_inc_q;

`ifdef ALARM_DEC_EN
  logic r_dec_q;

  // BCD step down with wrap to max; units digit 0 borrows from tens.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)
      return max;
    else if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_dec_q <= 1'b0;
    else       r_dec_q <= btn_dec;
  end

  assign w_dec_edge = btn_dec & ~r_dec_q;
`else
  logic w_dec_unused;
  assign w_dec_unused = btn_dec;
  assign w_dec_edge   = 1'b0;
`endif

  // Simultaneous inc and dec cancel out.
  assign w_inc_only  = w_inc_edge & ~w_dec_edge;
  assign w_dec_only  = w_dec_edge & ~w_inc_edge;

  assign w_edit_hour = (r_state == S_EDIT_HOUR);
  assign w_field     = w_edit_hour ? r_sh_hour : r_sh_min;
  assign w_field_max = w_edit_hour ? HOUR_MAX  : MIN_MAX;

  always_comb begin
    w_field_nxt = w_field;
    if (w_inc_only)
      w_field_nxt = bcd_inc(w_field, w_field_max);
`ifdef ALARM_DEC_EN
    else if (w_dec_only)
      w_field_nxt = bcd_dec(w_field, w_field_max);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_set_q  <= 1'b0;
      r_off_q  <= 1'b0;
      r_next_q <= 1'b0;
      r_inc_q  <= 1'b0;
    end else begin
      r_set_q  <= Set_Alarm;
      r_off_q  <= Alarm_off;
      r_next_q <= btn_next;
      r_inc_q  <= btn_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_com_hour <= RESET_HOUR_BCD;
      r_com_min  <= RESET_MIN_BCD;
      r_sh_hour  <= RESET_HOUR_BCD;
      r_sh_min   <= RESET_MIN_BCD;
      r_armed    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_set_edge) begin
            r_sh_hour <= r_com_hour;
            r_sh_min  <= r_com_min;
            r_state   <= S_EDIT_HOUR;
          end
        end
        S_EDIT_HOUR, S_EDIT_MIN: begin
          if (w_off_edge) begin
            r_state <= S_IDLE;
          end else if (w_next_edge) begin
            r_state <= w_edit_hour ? S_EDIT_MIN : S_COMMIT;
          end else if (w_inc_only || w_dec_only) begin
            if (w_edit_hour) r_sh_hour <= w_field_nxt;
            else             r_sh_min  <= w_field_nxt;
          end
        end
        S_COMMIT: begin
          r_com_hour <= r_sh_hour;
          r_com_min  <= r_sh_min;
          r_armed    <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign setting      = (r_state == S_EDIT_HOUR) || (r_state == S_EDIT_MIN);
  assign commit_pulse = (r_state == S_COMMIT);
  assign alarm_armed  = r_armed & ~setting;

  assign hour_al_tens = setting ? r_sh_hour[7:4] : r_com_hour[7:4];
  assign hour_al_unit = setting ? r_sh_hour[3:0] : r_com_hour[3:0];
  assign min_al_tens  = setting ? r_sh_min[7:4]  : r_com_min[7:4];
  assign min_al_unit  = setting ? r_sh_min[3:0]  : r_com_min[3:0];

  assign seg_al_tens  = 4'd0;
  assign seg_al_unit  = 4'd0;

endmodule

// File: tb/tb_alarm_setter.sv
// Randomized scoreboard bench for alarm_setter; reference model keeps the time as plain integers.
module tb_alarm_setter;

  localparam logic [4:0] M_SET  = 5'b00001;
  localparam logic [4:0] M_OFF  = 5'b00010;
  localparam logic [4:0] M_NEXT = 5'b00100;
  localparam logic [4:0] M_INC  = 5'b01000;
  localparam logic [4:0] M_DEC  = 5'b10000;
`ifdef ALARM_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, set_a, off_a, nxt, inc, dec;
  logic [3:0] hour_al_tens, hour_al_unit, min_al_tens, min_al_unit, seg_al_tens, seg_al_unit;
  logic setting, alarm_armed, commit_pulse;

  alarm_setter dut (
    .clk(clk), .reset(reset), .Set_Alarm(set_a), .Alarm_off(off_a),
    .btn_next(nxt), .btn_inc(inc), .btn_dec(dec),
    .hour_al_tens(hour_al_tens), .hour_al_unit(hour_al_unit),
    .min_al_tens(min_al_tens), .min_al_unit(min_al_unit),
    .seg_al_tens(seg_al_tens), .seg_al_unit(seg_al_unit),
    .setting(setting), .alarm_armed(alarm_armed), .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  // Reference model: mode 0 idle, 1 editing hour, 2 editing minute.
  int m_mode, m_ch, m_cm, m_sh, m_sm;
  bit m_armed;

  function automatic logic [15:0] bcd(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {hour_al_tens, hour_al_unit, min_al_tens, min_al_unit};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_state(input string tag);
    logic [15:0] disp;
    disp = (m_mode != 0) ? bcd(m_sh, m_sm) : bcd(m_ch, m_cm);
    chk({tag, " digits"}, digits(), disp);
    chk({tag, " flags"}, 16'({setting, alarm_armed, commit_pulse, seg_al_tens, seg_al_unit}),
        16'({m_mode != 0, m_armed && (m_mode == 0), 1'b0, 8'h00}));
  endtask

  task automatic model_reset();
    m_mode = 0; m_ch = 6; m_cm = 0; m_sh = 6; m_sm = 0; m_armed = 0;
  endtask

  task automatic apply(input logic [4:0] mask);
    bit s, o, n, i, d;
    s = mask[0]; o = mask[1]; n = mask[2]; i = mask[3]; d = mask[4] && DEC_EN;
    if (m_mode == 0) begin
      if (s) begin m_sh = m_ch; m_sm = m_cm; m_mode = 1; end
    end else if (o) begin
      m_mode = 0;
    end else if (n) begin
      if (m_mode == 1) m_mode = 2;
      else begin
        exp_q.push_back(bcd(m_sh, m_sm));
        m_ch = m_sh; m_cm = m_sm; m_armed = 1; m_mode = 0;
      end
    end else if (i && !d) begin
      if (m_mode == 1) m_sh = (m_sh + 1) % 24; else m_sm = (m_sm + 1) % 60;
    end else if (d && !i) begin
      if (m_mode == 1) m_sh = (m_sh + 23) % 24; else m_sm = (m_sm + 59) % 60;
    end
  endtask

  task automatic drive(input logic [4:0] mask);
    {dec, inc, nxt, off_a, set_a} = mask;
  endtask

  task automatic hold(input logic [4:0] mask, input int n, input string tag);
    @(negedge clk); drive(mask);
    @(posedge clk); apply(mask);
    repeat (n - 1) @(posedge clk);
    @(negedge clk); drive(5'b0);
    @(negedge clk); check_state(tag);
  endtask

  task automatic press(input logic [4:0] mask, input string tag);
    hold(mask, 1, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); drive(5'b0); reset = 1'b1; model_reset();
    @(negedge clk); check_state(tag);
    reset = 1'b0;
  endtask

  task automatic set_time(input int h, input int m);
    press(M_SET, "st_enter");
    repeat ((h - m_sh + 24) % 24) press(M_INC, "st_hour");
    press(M_NEXT, "st_next");
    repeat ((m - m_sm + 60) % 60) press(M_INC, "st_min");
    press(M_NEXT, "st_commit");
  endtask

  // Monitor: each commit pulse must match the oldest pending commit and be one cycle wide.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (commit_pulse === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_commit: commit_pulse=1 required 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          chk("commit_time", digits(), e);
          chk("commit_armed_pulse", 16'({alarm_armed, commit_pulse}), 16'b10);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    logic [4:0] mask;
    drive(5'b0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_digits", digits(), 16'h0600);
    chk("reset_flags", 16'({setting, alarm_armed, commit_pulse}), 16'b000);
    reset = 1'b0;

    // Basic edit and commit to 09:02
    press(M_SET, "e_set");
    chk("e_setting_high", 16'(setting), 16'd1);
    repeat (3) press(M_INC, "e_inc_h");
    press(M_NEXT, "e_next");
    repeat (2) press(M_INC, "e_inc_m");
    press(M_NEXT, "e_commit");
    chk("e_0902", digits(), 16'h0902);
    chk("e_armed", 16'(alarm_armed), 16'd1);

    // Wraps
    set_time(23, 59);
    press(M_SET, "w_set"); press(M_INC, "w_h23"); press(M_NEXT, "w_next");
    press(M_INC, "w_m59"); press(M_NEXT, "w_commit");
    chk("wrap_0000", digits(), 16'h0000);
    set_time(0, 9);
    press(M_SET, "w9_set"); press(M_NEXT, "w9_next"); press(M_INC, "w9_inc");
    press(M_NEXT, "w9_commit");
    chk("wrap_0010", digits(), 16'h0010);
`ifdef ALARM_DEC_EN
    press(M_SET, "d_set"); press(M_DEC, "d_dec"); press(M_NEXT, "d_next");
    press(M_NEXT, "d_commit");
    chk("dec_2310", digits(), 16'h2310);
`endif

    // Abort keeps the committed value
    set_time(7, 30);
    press(M_SET, "a_set"); repeat (2) press(M_INC, "a_inc"); press(M_OFF, "a_off");
    chk("abort_0730", digits(), 16'h0730);
    chk("abort_armed", 16'(alarm_armed), 16'd1);

    // Held button and Set_Alarm in EDIT_MIN
    press(M_SET, "h_set");
    hold(M_INC, 10, "h_hold");
    chk("held_one_inc", digits(), 16'h0830);
    press(M_NEXT, "h_next");
    press(M_SET, "h_set_in_min");
    chk("set_ignored_setting", 16'(setting), 16'd1);
    press(M_OFF, "h_off");

    // Priority, then reset mid-edit
    press(M_SET, "p_set");
    press(M_NEXT | M_INC, "p_next_inc");
    chk("prio_hour_kept", digits(), 16'h0730);
    do_reset("p_reset");
    chk("midreset_0600", digits(), 16'h0600);
    chk("midreset_setting", 16'(setting), 16'd0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) do_reset("rnd_reset");
      else begin
        if      (r < 40) mask = M_INC;
        else if (r < 55) mask = M_NEXT;
        else if (r < 68) mask = M_SET;
        else if (r < 73) mask = M_OFF;
        else if (r < 88) mask = M_DEC;
        else             mask = 5'($urandom_range(0, 31));
        press(mask, "rnd");
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_setter.md
ALARM_SETTER -- requirements
Module: alarm_setter

Interface
REQ-001 SHALL have parameter RESET_HOUR_BCD, default 8'h06, meaning the alarm hour loaded at reset as {tens,units} BCD.
REQ-002 SHALL have parameter RESET_MIN_BCD, default 8'h00, meaning the alarm minute loaded at reset as {tens,units} BCD.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Set_Alarm  input  1  level; its 0->1 edge enters edit mode.
REQ-006 SHALL have port Alarm_off  input  1  level; its 0->1 edge during edit aborts the edit.
REQ-007 SHALL have port btn_next  input  1  level; its 0->1 edge advances the edit field.
REQ-008 SHALL have port btn_inc  input  1  level; its 0->1 edge increments the field being edited.
REQ-009 SHALL have port btn_dec  input  1  level; its 0->1 edge decrements the field being edited (used only with ALARM_DEC_EN).
REQ-010 SHALL have ports hour_al_tens, hour_al_unit, min_al_tens, min_al_unit  output  4 each  alarm time BCD digits.
REQ-011 SHALL have ports seg_al_tens, seg_al_unit  output  4 each  alarm seconds digits, constant 0.
REQ-012 SHALL have port setting  output  1  high while in edit mode; drives display selection.
REQ-013 SHALL have port alarm_armed  output  1  high when a committed alarm is active.
REQ-014 SHALL have port commit_pulse  output  1  one-cycle pulse when an edit is committed.

Function
REQ-015 SHALL detect 0->1 edges on all five button inputs using one registered previous-sample per input; an edge acts on the same rising clk edge at which the input is first sampled 1 after being sampled 0.
REQ-016 SHALL hold two registers sets: committed {hour,min} and shadow {hour,min}, each as BCD digits.
REQ-017 SHALL implement states IDLE, EDIT_HOUR, EDIT_MIN, COMMIT.
REQ-018 SHALL, in IDLE on Set_Alarm edge, copy committed into shadow and go to EDIT_HOUR; all other edges in IDLE SHALL be ignored.
REQ-019 SHALL, in EDIT_HOUR, on btn_next edge go to EDIT_MIN; in EDIT_MIN, on btn_next edge go to COMMIT.
REQ-020 SHALL, in COMMIT, copy shadow into committed, set alarm_armed to 1, assert commit_pulse for exactly that one cycle, and go to IDLE next cycle.
REQ-021 SHALL, in EDIT_HOUR or EDIT_MIN on Alarm_off edge, discard shadow and return to IDLE with committed and alarm_armed unchanged.
REQ-022 SHALL increment the edited shadow field in BCD: hour 00..23 with 23->00, minute 00..59 with 59->00; units digit 9 carries into tens.
REQ-023 SHALL decrement (ALARM_DEC_EN only) in BCD: hour 00->23, minute 00->59; units 0 borrows from tens.
REQ-024 SHALL apply same-cycle edge priority: Alarm_off > btn_next > btn_inc > btn_dec; simultaneous inc and dec edges SHALL change nothing.
REQ-025 SHALL ignore Set_Alarm edges outside IDLE.
REQ-026 SHALL drive alarm digit outputs from shadow while setting=1 and from committed otherwise.
REQ-027 SHALL drive setting=1 exactly in EDIT_HOUR and EDIT_MIN, and alarm_armed output as armed-register AND NOT setting.

Reset
REQ-028 SHALL, while reset=1, force state IDLE, committed and shadow to RESET_HOUR_BCD:RESET_MIN_BCD, armed register 0, setting 0, commit_pulse 0, all edge-detect registers 0, seg_al_* 0.
REQ-029 SHALL, on reset asserted mid-edit, discard the edit with no commit_pulse.

Configuration
REQ-030 SHALL, with ALARM_DEC_EN defined, implement btn_dec per REQ-023 and REQ-024.
REQ-031 SHALL, without ALARM_DEC_EN, keep port btn_dec but ignore it entirely, including in the inc/dec simultaneity rule.

Verification
REQ-032 SHALL check reset: reset=1 -> digits 0,6,0,0, setting=0, alarm_armed=0, commit_pulse=0.
REQ-033 SHALL check edit/commit: Set_Alarm edge, 3 inc edges, next, 2 inc edges, next -> setting high during edit, commit_pulse one cycle, outputs 09:02, alarm_armed=1.
REQ-034 SHALL check wrap: hour 23 + inc -> 00; minute 59 + inc -> 00; minute 09 + inc -> 10; with ALARM_DEC_EN hour 00 + dec -> 23.
REQ-035 SHALL check abort: commit 07:30, edit hour to 09, Alarm_off edge -> outputs 07:30, alarm_armed=1, no commit_pulse.
REQ-036 SHALL check held buttons: btn_inc held high 10 cycles -> exactly one increment; Set_Alarm edge during EDIT_MIN -> no state change.
REQ-037 SHALL check priority and reset mid-edit: btn_next and btn_inc edges same cycle in EDIT_HOUR -> move to EDIT_MIN, hour unchanged; reset in EDIT_MIN -> 06:00, setting=0.
